// File: rtl/d_x_dispatch_pkg.sv
// Shared types for the decode-to-execute dispatch path: micro-op encoding,
// execute-unit classes and the buffered message layout.
package d_x_dispatch_pkg;

    localparam int unsigned ADDR_BITS = 32;
    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned UOP_BITS  = 5;

    typedef enum logic [UOP_BITS-1:0] {
        UOP_ADD,
        UOP_SUB,
        UOP_AND,
        UOP_OR,
        UOP_XOR,
        UOP_SLT,
        UOP_MUL,
        UOP_DIV,
        UOP_LW,
        UOP_SW,
        UOP_BEQ,
        UOP_BNE,
        UOP_JAL
    } rv_uop;

    typedef enum logic [1:0] {
        UNIT_ALU  = 2'd0,
        UNIT_MUL  = 2'd1,
        UNIT_MEM  = 2'd2,
        UNIT_CTRL = 2'd3
    } exec_unit_e;

    typedef struct packed {
        logic [ADDR_BITS-1:0] pc;
        logic [DATA_BITS-1:0] op1;
        logic [DATA_BITS-1:0] op2;
        rv_uop                uop;
    } d_x_msg_t;

    function automatic exec_unit_e uop_unit(input rv_uop uop);
        case (uop)
            UOP_MUL, UOP_DIV:          return UNIT_MUL;
            UOP_LW, UOP_SW:            return UNIT_MEM;
            UOP_BEQ, UOP_BNE, UOP_JAL: return UNIT_CTRL;
            default:                   return UNIT_ALU;
        endcase
    endfunction

endpackage

// File: rtl/d_x_dispatch_queue.sv
// Two-entry in-order buffer with enqueue, dequeue and flush; flush wins over
// everything and returns both pointers to zero.
module d_x_dispatch_queue #(
    parameter int unsigned p_width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq,
    input  logic [p_width-1:0] enq_data,
    input  logic               deq,
    input  logic               flush,
    output logic [p_width-1:0] head_data,
    output logic [1:0]         count
);

    logic [p_width-1:0] mem [2];
    logic               head_q, head_d;
    logic               tail_q, tail_d;
    logic [1:0]         count_q, count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry contents need no reset; count gates their visibility.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            mem[tail_q] <= enq_data;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (enq) begin
                tail_d = ~tail_q;
            end
            if (deq) begin
                head_d = ~head_q;
            end
            if (enq && !deq) begin
                count_d = count_q + 2'd1;
            end else if (deq && !enq) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    assign head_data = mem[head_q];
    assign count     = count_q;

endmodule

// File: rtl/d_x_dispatch.sv
// D->X dispatch: buffers decoded micro-ops, steers the head entry to one
// execute unit by class and merges unit squashes back to decode.
module d_x_dispatch
    import d_x_dispatch_pkg::*;
#(
    parameter int unsigned p_addr_bits = 32,
    parameter int unsigned p_data_bits = 32,
    parameter int unsigned p_num_units = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               d_val,
    output logic                               d_rdy,
    input  logic [p_addr_bits-1:0]             d_pc,
    input  logic [p_data_bits-1:0]             d_op1,
    input  logic [p_data_bits-1:0]             d_op2,
    input  rv_uop                              d_uop,
    output logic                               d_squash,
    output logic [p_addr_bits-1:0]             d_branch_target,
    output logic [p_num_units-1:0]             x_val,
    input  logic [p_num_units-1:0]             x_rdy,
    output logic [p_addr_bits-1:0]             x_pc,
    output logic [p_data_bits-1:0]             x_op1,
    output logic [p_data_bits-1:0]             x_op2,
    output rv_uop                              x_uop,
    input  logic [p_num_units-1:0]             x_squash,
    input  logic [p_num_units*p_addr_bits-1:0] x_branch_target
);

    localparam int unsigned MsgBits = p_addr_bits + 2 * p_data_bits + UOP_BITS;

    logic [MsgBits-1:0] enq_data;
    logic [MsgBits-1:0] head_data;
    logic [1:0]         count;
    logic               squash_any;
    logic               enq;
    logic               deq;
    exec_unit_e         head_class;
    logic [1:0]         head_unit;

    assign enq_data = {d_pc, d_op1, d_op2, d_uop};

    d_x_dispatch_queue #(
        .p_width (MsgBits)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq),
        .enq_data  (enq_data),
        .deq       (deq),
        .flush     (squash_any),
        .head_data (head_data),
        .count     (count)
    );

    assign x_pc  = head_data[MsgBits-1 -: p_addr_bits];
    assign x_op1 = head_data[UOP_BITS + p_data_bits +: p_data_bits];
    assign x_op2 = head_data[UOP_BITS +: p_data_bits];
    assign x_uop = rv_uop'(head_data[UOP_BITS-1:0]);

    // Registered-state only, so x_rdy never reaches d_rdy combinationally.
    assign d_rdy = (count < 2'd2);

    // A micro-op offered during a squash is younger than the squasher: drop it.
    assign enq = d_val && d_rdy && !squash_any;

    always_comb begin
        head_class = uop_unit(x_uop);
        if (32'(head_class) < p_num_units) begin
            head_unit = 2'(head_class);
        end else begin
            head_unit = 2'd0;
        end
    end

    assign squash_any = |x_squash;
    assign d_squash   = squash_any;

    // x_squash reaches x_val combinationally so a squashed head never issues.
    always_comb begin
        x_val = '0;
        for (int unsigned i = 0; i < p_num_units; i++) begin
            x_val[i] = (count != 2'd0) && (head_unit == 2'(i)) && !squash_any;
        end
    end

    assign deq = |(x_val & x_rdy);

    // Scan high to low so the lowest-index squashing unit supplies the target.
    always_comb begin
        d_branch_target = '0;
        for (int i = int'(p_num_units) - 1; i >= 0; i--) begin
            if (x_squash[i]) begin
                d_branch_target = x_branch_target[i*p_addr_bits +: p_addr_bits];
            end
        end
    end

endmodule

// File: doc/d_x_dispatch.md
Name: d_x_dispatch

Overview:
- Sits between the decode stage and N execute units on the D→X path.
- Buffers decoded micro-ops in a 2-entry in-order queue and routes each head entry to exactly one execute unit, selected by its uop class.
- Merges the units' squash / branch_target signals into the single squash returned to decode, and flushes buffered younger micro-ops on squash.

Parameters:
- p_addr_bits, 32, width of pc and branch_target.
- p_data_bits, 32, width of op1/op2.
- p_num_units, 2, number of downstream execute units (legal 1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- d_val  in  1  decode has a micro-op.
- d_rdy  out  1  block accepts the micro-op.
- d_pc  in  p_addr_bits  micro-op pc.
- d_op1  in  p_data_bits  operand 1.
- d_op2  in  p_data_bits  operand 2.
- d_uop  in  rv_uop  micro-op.
- d_squash  out  1  squash to decode.
- d_branch_target  out  p_addr_bits  redirect target to decode.
- x_val  out  p_num_units  per-unit valid (one-hot or zero).
- x_rdy  in  p_num_units  per-unit ready.
- x_pc  out  p_addr_bits  head pc, broadcast to all units.
- x_op1  out  p_data_bits  head op1, broadcast.
- x_op2  out  p_data_bits  head op2, broadcast.
- x_uop  out  rv_uop  head uop, broadcast.
- x_squash  in  p_num_units  per-unit squash request.
- x_branch_target  in  p_num_units*p_addr_bits  per-unit targets; unit i occupies bits [i*p_addr_bits +: p_addr_bits].

Behaviour:
- Storage:
  - 2-entry circular buffer {pc, op1, op2, uop}; head ptr, tail ptr (1 bit each), count (0..2).
  - Reset: count=0, ptrs=0. Entry contents are don't-care.
  - Outputs under reset: x_val=0, d_rdy=1, d_squash follows x_squash.
- Enqueue: d_rdy = (count < 2), derived from registered state only; no combinational path from x_rdy to d_rdy.
- Routing:
  - head_unit = uop_unit(head.uop).
  - x_val[i] = (count>0) & (i==head_unit) & !squash_any.
  - x_pc/op1/op2/uop are always driven from the head entry, even when invalid.
- Dequeue when x_val[head_unit] & x_rdy[head_unit].
- Latency and throughput:
  - An accepted micro-op is visible at x_* the cycle after acceptance.
  - Sustained 1 micro-op/cycle when the target unit is always ready.
- Simultaneous enqueue and dequeue:
  - count unchanged, both pointers advance.
  - Legal at count=1; at count=2 only dequeue occurs because d_rdy=0.
- Squash:
  - squash_any = |x_squash.
  - d_squash = squash_any.
  - d_branch_target = target of the lowest-index asserting unit.
  - Multiple simultaneous squashes: lowest index wins.
  - At the next edge: count=0, head=tail=0. Any micro-op accepted from decode in the squash cycle is discarded, since it is younger than the squashing instruction.
  - x_val is forced to 0 in the squash cycle (combinational x_squash→x_val path, documented).
  - When no squash is active, d_branch_target = '0.
- uop_unit mapping:
  - uop_unit returns an index < p_num_units.
  - Any class mapping ≥ p_num_units falls back to unit 0.
- Unit not ready: the head entry holds; its pc/op1/op2/uop stay stable while x_val is high (val/rdy stability rule).
- Reset mid-operation: the buffer empties immediately (async); no x_val pulse is produced after rst rises.

Decomposition:
- Shared package (alongside ISA):
  - exec_unit_e enum (UNIT_ALU=0, UNIT_MUL=1, UNIT_MEM=2, UNIT_CTRL=3).
  - Function uop_unit(rv_uop) → exec_unit_e.
  - Packed struct d_x_msg_t {pc, op1, op2, uop}, parameterized by width localparams.
- Sub-module: d_x_dispatch_queue (2-entry in-order buffer with enq/deq/flush, count output). The routing and squash-merge logic stays in the top level.

Test Plan:
- Basic routing: send ADD (pc 0x200, op1 5, op2 7), then MUL (pc 0x204); both units always ready → x_val=01 at cycle 1 with pc 0x200; x_val=10 at cycle 2 with pc 0x204.
- Back-pressure: hold x_rdy[0]=0 and send 3 ADDs → d_rdy=0 after 2 accepts; head pc 0x200 stays stable; on x_rdy[0]=1, drain in order 0x200, 0x204, 0x208 on consecutive cycles.
- Squash flush: queue holds pc 0x300 and 0x304; assert x_squash[0] with target 0x400 for 1 cycle while d_val=1 (pc 0x308) → d_squash=1 and d_branch_target=0x400 in that cycle; x_val=0; next cycle count=0 and 0x308 never appears at x_*.
- Simultaneous squash: x_squash=11, targets 0x500 / 0x600 → d_branch_target=0x500.
- Async reset mid-stream: rst rises between edges with count=2 → x_val=0 immediately, d_rdy=1; after release, the first new micro-op issues 1 cycle after acceptance.
- Full throughput: 16 alternating ALU/MUL micro-ops with all units ready → one issue per cycle, 16 issues in 17 cycles, order preserved.
